// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scan driver.
package seg_pkg;

    // All segments and the decimal point dark (active-low).
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
    localparam logic [6:0] HEX7 [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // True when digit i is a zero with only zeros above it. The word is
    // zero-padded to 16 nibbles, so the padding never defeats the test.
    // Digit 0 always shows, so a zero value still reads as "0".
    function automatic logic digit_is_leading_zero(input logic [63:0] data, input int i);
        logic all_zero;
        all_zero = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k >= i && data[k*4 +: 4] != 4'h0) all_zero = 1'b0;
        end
        return (i != 0) && all_zero;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX7[nibble_i];

endmodule

// File: rtl/seg_scan_display.sv
// N-digit multiplexed seven-segment scan driver. Input data is captured
// into shadow registers once per frame so a frame never mixes two values.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int CLK_DIV  = 100000,
    parameter int FAST_DIV = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  lz_suppress,
    input  logic                  fast,
    input  logic                  enable,
    output logic [DIGITS-1:0]     AN,
    output logic [7:0]            SEG,
    output logic                  frame_done
);

    localparam int PRE_W = $clog2(CLK_DIV) + 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PRE_W-1:0] SLOW_LIM = PRE_W'(CLK_DIV - 1);
    localparam logic [PRE_W-1:0] FAST_LIM = PRE_W'(FAST_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] sh_data_q;
    logic [DIGITS-1:0]   sh_dp_q;
    logic [DIGITS-1:0]   sh_blank_q;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [7:0]          seg_q, seg_d;
    logic                frame_done_q;

    logic [PRE_W-1:0]    div_lim;
    logic                tick;
    logic                wrap;
    logic [3:0]          cur_nibble;
    logic [6:0]          cur_seg7;
    logic                cur_blank;
    logic                cur_dp;
    logic                cur_lz;

    // A ">=" compare lets a mid-count switch to fast mode tick at once.
    assign div_lim = fast ? FAST_LIM : SLOW_LIM;
    assign tick    = enable && (pre_q >= div_lim);
    assign wrap    = tick && (idx_q == LAST_IDX);

    assign cur_nibble = sh_data_q[{idx_q, 2'b00} +: 4];
    assign cur_blank  = sh_blank_q[idx_q];
    assign cur_dp     = sh_dp_q[idx_q];
    assign cur_lz     = lz_suppress && digit_is_leading_zero(64'(sh_data_q), int'(idx_q));

    hex_to_seg7 u_dec (
        .nibble_i (cur_nibble),
        .seg_o    (cur_seg7)
    );

    // Prescaler and scan index next state; both freeze while disabled.
    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        pre_d = pre_q;
        idx_d = idx_q;
        if (enable) begin
            pre_d = tick ? '0 : pre_q + PRE_W'(1);
        end
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Anode and segment pattern for the digit currently selected.
    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        if (enable) begin
            an_d = ~(DIGITS'(1) << idx_q);
            if (cur_blank)   seg_d = SEG_OFF;
            else if (cur_lz) seg_d = {~cur_dp, 7'h7F};
            else             seg_d = {~cur_dp, cur_seg7};
        end
    end

    // Counters, output registers and frame pulse.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep all state updating on the same edge.
        if (rst) begin
            pre_q        <= '0;
            idx_q        <= '0;
            an_q         <= '1;
            seg_q        <= SEG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= wrap;
        end
    end

    // Shadow capture at reset and at frame wrap only.
    always_ff @(posedge clk) begin
        // NOTE: shadows load from the inputs during reset instead of clearing,
        // so the first frame after reset already shows live data.
        if (rst || wrap) begin
            sh_data_q  <= data;
            sh_dp_q    <= dp;
            sh_blank_q <= blank;
        end
    end

    assign AN         = an_q;
    assign SEG        = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench: stimulus queues expected display events and frame
// spacings; a negedge monitor pops and compares on every output change.
module tb_seg_scan_display;

    localparam int T0 = 3;   // last reset edge; edge T0+n is "E n"

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data;
    logic [7:0]  dp, blank;
    logic        lz_suppress, fast, enable;
    logic [7:0]  an, seg;
    logic        frame_done;

    always #5 clk = ~clk;

    seg_scan_display #(.DIGITS(8), .CLK_DIV(10), .FAST_DIV(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .data        (data),
        .dp          (dp),
        .blank       (blank),
        .lz_suppress (lz_suppress),
        .fast        (fast),
        .enable      (enable),
        .AN          (an),
        .SEG         (seg),
        .frame_done  (frame_done)
    );

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] seg;
        int         dwell;   // cycles since previous change, 0 = don't care
    } ev_t;

    ev_t         exp_q[$];
    int          fd_q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          armed = 1'b0;
    logic [15:0] prev_out;
    logic        prev_fd;
    int          gap;
    int          fd_gap;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] an_of(input int k);
        return ~(8'h01 << k);
    endfunction

    task automatic push_ev(input logic [7:0] a, input logic [7:0] s, input int dwell);
        ev_t e;
        e.an    = a;
        e.seg   = s;
        e.dwell = dwell;
        exp_q.push_back(e);
    endtask

    // segs holds digit k's SEG byte at [k*8 +: 8]; first digit has dwell d0.
    task automatic push_frame(input logic [63:0] segs, input int d0);
        for (int k = 0; k < 8; k++) push_ev(an_of(k), segs[k*8 +: 8], (k == 0) ? d0 : 2);
    endtask

    // Monitor: one comparison set per observed output change and frame pulse.
    always @(negedge clk) begin
        ev_t e;
        int  f;
        if (armed) begin
            gap++;
            fd_gap++;
            if ({an, seg} !== prev_out) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_change@cyc%0d: got AN=%h SEG=%h, required no change", cyc, an, seg);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("AN@cyc%0d", cyc), an, e.an);
                    check($sformatf("SEG@cyc%0d", cyc), seg, e.seg);
                    if (e.dwell != 0) check($sformatf("dwell@cyc%0d", cyc), gap, e.dwell);
                end
                gap      = 0;
                prev_out = {an, seg};
            end
            if (frame_done === 1'b1) begin
                check($sformatf("frame_done_width@cyc%0d", cyc), prev_fd, 0);
                if (fd_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame_done@cyc%0d: got pulse, required none", cyc);
                end else begin
                    f = fd_q.pop_front();
                    check($sformatf("frame_spacing@cyc%0d", cyc), fd_gap, f);
                end
                fd_gap = 0;
            end
            prev_fd = frame_done;
        end
    end

    initial begin
        #10000;
        $display("FAIL watchdog: got cyc=%0d, required completion", cyc);
        $fatal(1, "watchdog expired");
    end

    localparam logic [63:0] F_HEX  = 64'hF9A4B0998883C6A1;  // 1234ABCD
    localparam logic [63:0] F_ZERO = 64'hC0C0C0C0C0C0C0C0;
    localparam logic [63:0] F_LZ50 = 64'hFFFFFFFFFF7F92C0;
    localparam logic [63:0] F_LZ0  = 64'hFFFFFFFFFFFFFFC0;
    localparam logic [63:0] F_BL8  = 64'hFF80808080808080;
    localparam logic [63:0] F_SEQ  = 64'hF8829299B0A4F9C0;  // 76543210

    initial begin
        logic [63:0] segs;
        segs        = F_SEQ;
        rst         = 1'b1;
        data        = 32'h1234ABCD;
        dp          = 8'h00;
        blank       = 8'h00;
        lz_suppress = 1'b0;
        fast        = 1'b1;
        enable      = 1'b1;

        // Reset state.
        goto(2);
        check("reset_AN", an, 8'hFF);
        check("reset_SEG", seg, 8'hFF);
        check("reset_frame_done", frame_done, 0);

        // Plain scan, then a second frame with the same shadow.
        goto(T0);
        rst      = 1'b0;
        prev_out = 16'hFFFF;
        prev_fd  = 1'b0;
        gap      = 0;
        fd_gap   = 0;
        armed    = 1'b1;
        push_frame(F_HEX, 2);
        push_frame(F_HEX, 2);
        fd_q.push_back(17);
        fd_q.push_back(16);

        // Data change mid-frame 2 shows only from frame 3.
        goto(T0 + 23);
        data = 32'h0;
        push_frame(F_ZERO, 2);
        fd_q.push_back(16);

        // Leading-zero suppression with a dp on a suppressed digit.
        goto(T0 + 40);
        data = 32'h0000_0050;
        dp   = 8'h04;
        push_frame(F_LZ50, 2);
        fd_q.push_back(16);
        goto(T0 + 48);
        lz_suppress = 1'b1;
        goto(T0 + 56);
        data = 32'h0;
        dp   = 8'h00;
        push_frame(F_LZ0, 2);
        fd_q.push_back(16);

        // Blank beats dp on digit 7.
        goto(T0 + 72);
        data  = 32'h8888_8888;
        dp    = 8'h80;
        blank = 8'h80;
        push_frame(F_BL8, 2);
        fd_q.push_back(16);
        goto(T0 + 80);
        lz_suppress = 1'b0;

        // Enable drop while digit 3 shows, then reset while digit 5 shows.
        goto(T0 + 88);
        for (int k = 0; k < 4; k++) push_ev(an_of(k), 8'h80, 2);
        push_ev(8'hFF, 8'hFF, 1);
        push_ev(an_of(3), 8'h80, 10);
        push_ev(an_of(4), 8'h80, 1);
        push_ev(an_of(5), 8'h80, 2);
        push_ev(8'hFF, 8'hFF, 1);
        goto(T0 + 103);
        enable = 1'b0;
        goto(T0 + 113);
        enable = 1'b1;
        goto(T0 + 117);
        rst   = 1'b1;
        data  = 32'h7654_3210;
        dp    = 8'h00;
        blank = 8'h00;
        push_frame(F_SEQ, 2);
        fd_q.push_back(39);
        goto(T0 + 119);
        rst = 1'b0;

        // Slow frame, then switch to fast with pre=6.
        goto(T0 + 135);
        fast = 1'b0;
        push_ev(an_of(0), segs[7:0], 2);
        for (int k = 1; k < 8; k++) push_ev(an_of(k), segs[k*8 +: 8], 10);
        push_ev(an_of(0), segs[7:0], 10);
        for (int k = 1; k < 8; k++) push_ev(an_of(k), segs[k*8 +: 8], (k == 1) ? 7 : 2);
        push_frame(F_SEQ, 2);
        push_ev(an_of(0), segs[7:0], 2);
        fd_q.push_back(80);
        fd_q.push_back(21);
        fd_q.push_back(16);
        goto(T0 + 221);
        fast = 1'b1;

        goto(T0 + 254);
        check("events_left", exp_q.size(), 0);
        check("frame_pulses_left", fd_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
